// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix pins and key strobe bundle.
// rows/cols face the keypad; newkey/keycode feed the core.
interface keypad_scanner_if;
  logic [4:0] rows;
  logic [4:0] cols;
  logic       newkey;
  logic [4:0] keycode;

  modport master (
    input  rows,
    output cols,
    output newkey,
    output keycode
  );

  modport slave (
    output rows,
    input  cols,
    input  newkey,
    input  keycode
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 5x5 active-low matrix scan, debounce, keycode.
// Ports: clock, reset (sync, high), kp (rows in; cols/newkey/keycode out).
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW:0]   DB = (CW+1)'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAND,
    S_HELD
  } state_t;

  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [DW-1:0] r_div;
  logic [2:0]    r_col;
  logic [4:0]    r_cols;
  logic [1:0]    r_acc_n;
  logic [4:0]    r_acc_idx;

  state_t        r_state;
  logic [4:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rel;
  logic          r_newkey;
  logic [4:0]    r_keycode;

  logic          w_sample;
  logic          w_eval;
  logic [1:0]    w_col_n;
  logic [4:0]    w_col_idx;
  logic [1:0]    w_tot_n;
  logic [4:0]    w_tot_idx;
  logic          w_none;
  logic          w_single;
  logic [CW:0]   w_cnt_nx;
  logic [CW:0]   w_rel_nx;

  function automatic logic [4:0] f_map(input logic [4:0] idx);
    unique case (1'b1)
      (idx < 5'd16):  f_map = {1'b1, idx[3:0]};
      (idx == 5'd16): f_map = 5'b01001;
      (idx == 5'd17): f_map = 5'b01010;
      (idx == 5'd18): f_map = 5'b00001;
      (idx == 5'd19): f_map = 5'b00100;
      (idx == 5'd20): f_map = 5'b00010;
      (idx == 5'd21): f_map = 5'b01100;
      default:        f_map = 5'b00000;
    endcase
  endfunction

  assign w_sample = (r_div == DIV_LAST);
  assign w_eval   = w_sample && (r_col == 3'd4);

  // Closed mapped keys on the driven column; count saturates at 2
  // since only none/one/many matters.
  always_comb begin
    w_col_n   = 2'd0;
    w_col_idx = 5'd0;
    for (int r = 0; r < 5; r++) begin
      if (!r_sync2[r] &&
          (5'(r * 5) + {2'b00, r_col}) < 5'd22) begin
        if (w_col_n == 2'd0)
          w_col_idx = 5'(r * 5) + {2'b00, r_col};
        if (w_col_n != 2'd2)
          w_col_n = w_col_n + 2'd1;
      end
    end
  end

  // Fold this column into the running scan result.
  always_comb begin
    if (r_acc_n == 2'd0) begin
      w_tot_n   = w_col_n;
      w_tot_idx = w_col_idx;
    end else begin
      w_tot_idx = r_acc_idx;
      w_tot_n   = (w_col_n == 2'd0) ? r_acc_n : 2'd2;
    end
  end

  assign w_none   = (w_tot_n == 2'd0);
  assign w_single = (w_tot_n == 2'd1);
  assign w_cnt_nx = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_rel_nx = {1'b0, r_rel} + (CW+1)'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= 5'h1f;
      r_sync2   <= 5'h1f;
      r_div     <= '0;
      r_col     <= 3'd0;
      r_cols    <= 5'b11110;
      r_acc_n   <= 2'd0;
      r_acc_idx <= 5'd0;
    end else begin
      r_sync1 <= kp.rows;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_div  <= '0;
        r_cols <= {r_cols[3:0], r_cols[4]};
        if (r_col == 3'd4) begin
          r_col     <= 3'd0;
          r_acc_n   <= 2'd0;
          r_acc_idx <= 5'd0;
        end else begin
          r_col     <= r_col + 3'd1;
          r_acc_n   <= w_tot_n;
          r_acc_idx <= w_tot_idx;
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cand    <= 5'd0;
      r_cnt     <= '0;
      r_rel     <= '0;
      r_newkey  <= 1'b0;
      r_keycode <= 5'd0;
    end else begin
      r_newkey <= 1'b0;
      if (w_eval) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_tot_idx;
              if (DEBOUNCE == 1) begin
                r_newkey  <= 1'b1;
                r_keycode <= f_map(w_tot_idx);
                r_state   <= S_HELD;
                r_cnt     <= '0;
                r_rel     <= '0;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_CAND;
              end
            end
          end
          S_CAND: begin
            if (w_single && w_tot_idx == r_cand) begin
              if (w_cnt_nx == DB) begin
                r_newkey  <= 1'b1;
                r_keycode <= f_map(r_cand);
                r_state   <= S_HELD;
                r_cnt     <= '0;
                r_rel     <= '0;
              end else begin
                r_cnt <= w_cnt_nx[CW-1:0];
              end
            end else if (w_single) begin
              r_cand <= w_tot_idx;
              r_cnt  <= CW'(1);
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_rel   <= '0;
            end
          end
          S_HELD: begin
            if (w_none) begin
              if (w_rel_nx == DB) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_rel   <= '0;
              end else begin
                r_rel <= w_rel_nx[CW-1:0];
              end
            end else begin
              r_rel <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rel   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.cols    = r_cols;
  assign kp.newkey  = r_newkey;
  assign kp.keycode = r_keycode;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix model, vector table and scoreboard
// for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 5 * SD;

  typedef struct {
    int         idx;
    bit         exp;
    logic [4:0] code;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [24:0] keys;
  logic [4:0]  w_rows;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp   (kif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key matrix: a closed key pulls its row low when its column is driven.
  always_comb begin
    w_rows = 5'h1f;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (!kif.cols[c] && keys[r*5+c])
          w_rows[r] = 1'b0;
  end
  assign kif.rows = w_rows;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_pulse = 0;
  logic [4:0] q[$];
  logic       prev_nk = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Scoreboard: every pulse must match the oldest expected keycode.
  always @(negedge clock) begin
    if (kif.newkey) begin
      last_pulse = cyc;
      chk("pulse_one_cycle", {31'd0, prev_nk}, 0);
      chk("pulse_not_in_reset", {31'd0, reset}, 0);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got keycode %b, expected no pulse",
                 kif.keycode);
      end else begin
        chk("keycode", {27'd0, kif.keycode}, {27'd0, q.pop_front()});
      end
    end
    prev_nk = kif.newkey;
  end

  task automatic scans(int n);
    repeat (n * SCAN) @(negedge clock);
  endtask

  task automatic drained(string nm, int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  vec_t vt[10];

  initial begin
    logic [4:0] ec;
    bit         ok;
    int         p;
    int         n;

    vt[0] = '{7,  1'b1, 5'b10111};
    vt[1] = '{0,  1'b1, 5'b10000};
    vt[2] = '{15, 1'b1, 5'b11111};
    vt[3] = '{16, 1'b1, 5'b01001};
    vt[4] = '{17, 1'b1, 5'b01010};
    vt[5] = '{18, 1'b1, 5'b00001};
    vt[6] = '{20, 1'b1, 5'b00010};
    vt[7] = '{21, 1'b1, 5'b01100};
    vt[8] = '{22, 1'b0, 5'b00000};
    vt[9] = '{24, 1'b0, 5'b00000};

    reset = 1'b1;
    keys  = '0;
    repeat (3) @(negedge clock);

    // Reset state and column walk.
    reset = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 2 * SCAN; k++) begin
      if (k > 0) @(negedge clock);
      ec = ~(5'b00001 << ((k / SD) % 5));
      chk("cols_walk", {27'd0, kif.cols}, {27'd0, ec});
      if (kif.newkey !== 1'b0 || kif.keycode !== 5'd0) ok = 1'b0;
    end
    chk("idle_outputs_zero", {31'd0, ok}, 1);

    // Clean press/release table.
    for (int i = 0; i < 10; i++) begin
      keys = '0;
      keys[vt[i].idx] = 1'b1;
      p = cyc;
      if (vt[i].exp) q.push_back(vt[i].code);
      scans(5);
      keys = '0;
      drained($sformatf("press_%0d", vt[i].idx), 1);
      if (vt[i].exp)
        chk($sformatf("latency_%0d", vt[i].idx),
            {31'd0, (last_pulse - p) <= (DB + 1) * SCAN + 3}, 1);
      scans(5);
    end

    // Bounce on key 21, then stable.
    keys = '0;
    for (int t = 0; t < 5; t++) begin
      keys[21] = ~keys[21];
      repeat (7) @(negedge clock);
    end
    keys[21] = 1'b1;
    q.push_back(5'b01100);
    scans(6);
    keys = '0;
    drained("bounce_21", 1);
    scans(5);

    // Ghosting and unused keys.
    keys[16] = 1'b1;
    keys[17] = 1'b1;
    scans(5);
    keys = '0;
    scans(5);
    keys[23] = 1'b1;
    scans(5);
    keys = '0;
    scans(5);
    keys[19] = 1'b1;
    q.push_back(5'b00100);
    scans(5);
    keys = '0;
    drained("after_multi_19", 1);
    scans(5);

    // Held key slides from 3 to 4 without a release.
    keys[3] = 1'b1;
    q.push_back(5'b10011);
    scans(5);
    drained("hold_3", 1);
    keys = '0;
    keys[4] = 1'b1;
    scans(5);
    keys = '0;
    scans(5);
    keys[4] = 1'b1;
    q.push_back(5'b10100);
    scans(5);
    keys = '0;
    drained("press_4_after_slide", 1);
    scans(5);

    // Reset while a candidate is pending, key held through it.
    keys[0] = 1'b1;
    repeat (45) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_keycode", {27'd0, kif.keycode}, 0);
    reset = 1'b0;
    q.push_back(5'b10000);
    ok = 1'b1;
    n = 0;
    while (!kif.newkey && n < 5 * SCAN) begin
      @(negedge clock);
      n++;
      if (!kif.newkey && kif.keycode !== 5'd0) ok = 1'b0;
    end
    chk("keycode_zero_till_pulse", {31'd0, ok}, 1);
    chk("reset_latency",
        {31'd0, n >= 2 * SCAN && n <= DB * SCAN + 3}, 1);
    @(negedge clock);
    drained("reset_press_0", 2);
    scans(3);
    keys = '0;
    scans(5);
    chk("queue_final", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
